// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the parametrised FIFO family.
// No per-instance state: every item here depends only on its arguments.
package fifo_pkg;

  typedef int unsigned fifo_dim_t;

  function automatic fifo_dim_t fifo_aw(input fifo_dim_t depth);
    return fifo_dim_t'($clog2(depth));
  endfunction

  // Pointers carry one extra wrap bit above the memory address.
  function automatic fifo_dim_t fifo_pw(input fifo_dim_t depth);
    return fifo_aw(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: PW-bit counter with increment and synchronous clear.
// Latency: updates on the clk edge; clear wins over increment.
// Backpressure: none, the caller gates inc with its accept condition.
module fifo_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, thresholds, flush and sticky error flags.
// Latency: status 1 cycle after accept; rd_data registered, or combinational with SYNC_FIFO_FWFT_EN.
// Backpressure: writes to full / reads from empty are dropped and latch overflow / underflow.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = int'(fifo_aw(DEPTH));
  localparam int PW = int'(fifo_pw(DEPTH));

  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // A read frees a slot in the same cycle, so a full FIFO still takes a concurrent write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && !rd_acc) underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always on the output; a read just advances to the next one.
  assign rd_data = mem[rd_ptr[AW-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_acc && !flush) begin
      rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DEPTH=8, WIDTH=8); also covers the SYNC_FIFO_FWFT_EN build.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH     (8),
    .DEPTH     (8),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Head-of-queue check before a read edge (FWFT) or after it (registered).
  task automatic rd_chk_pre(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, 32'(rd_data), 32'(exp));
`endif
  endtask

  task automatic rd_chk_post(input string tag, input logic [7:0] exp);
`ifndef SYNC_FIFO_FWFT_EN
    chk(tag, 32'(rd_data), 32'(exp));
`endif
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    rd_chk_pre(tag, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    rd_chk_post(tag, exp);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ae",    32'(almost_empty), 1);
    chk("rst_af",    32'(almost_full), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_unf",   32'(underflow), 0);
    rd_chk_post("rst_rd", 8'h00);

    // Fill 0x01..0x08, watching thresholds step by step.
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af",    32'(almost_full), (i >= 6) ? 1 : 0);
      chk("fill_ae",    32'(almost_empty), (i <= 2) ? 1 : 0);
      chk("fill_full",  32'(full), (i == 8) ? 1 : 0);
    end

    push(8'hAA);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_full",  32'(full), 1);

    for (int i = 1; i <= 8; i++) begin
      pop("drain_data", 8'(i));
      chk("drain_count", 32'(count), 32'(8 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    chk("ovf_sticky",  32'(overflow), 1);

    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_flag",  32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
    rd_chk_post("unf_hold", 8'h08);

    do_flush();
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_unf", 32'(underflow), 0);

    // Flush beats a concurrent write and read.
    push(8'hE1);
    push(8'hE2);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hE3;
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("fpri_count", 32'(count), 0);
    chk("fpri_empty", 32'(empty), 1);
    chk("fpri_ovf",   32'(overflow), 0);
    chk("fpri_unf",   32'(underflow), 0);

    // Full FIFO: write+read together keeps occupancy at 8.
    for (int i = 1; i <= 8; i++) push(8'(8'h10 + i));
    rd_chk_pre("sfull_rd", 8'h11);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    rd_chk_post("sfull_rd", 8'h11);
    chk("sfull_count", 32'(count), 8);
    chk("sfull_ovf",   32'(overflow), 0);
    chk("sfull_full",  32'(full), 1);
    for (int i = 2; i <= 8; i++) pop("sfull_drain", 8'(8'h10 + i));
    pop("sfull_last", 8'h55);
    chk("sfull_empty", 32'(empty), 1);

    // Empty FIFO: write+read together, only the write lands.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h66;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sempty_count", 32'(count), 1);
    chk("sempty_unf",   32'(underflow), 1);
    chk("sempty_empty", 32'(empty), 0);
    pop("sempty_data", 8'h66);
    do_flush();

    // Wrap: 23 writes push the 4-bit pointers past 16.
    for (int i = 0; i < 3; i++) push(8'(8'hA0 + i));
    for (int k = 0; k < 20; k++) begin
      rd_chk_pre("wrap_data", 8'(8'hA0 + k));
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'hA3 + k);
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      rd_chk_post("wrap_data", 8'(8'hA0 + k));
      chk("wrap_count", 32'(count), 3);
      chk("wrap_full",  32'(full), 0);
    end
    for (int i = 20; i < 23; i++) pop("wrap_tail", 8'(8'hA0 + i));
    chk("wrap_empty", 32'(empty), 1);

    // Single word into an empty FIFO; in FWFT it shows without rd_en.
    push(8'h3C);
    chk("one_empty", 32'(empty), 0);
    pop("one_data", 8'h3C);
    chk("one_drained", 32'(empty), 1);

    // Reset mid-operation discards contents.
    push(8'h77);
    push(8'h78);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
